// File: rtl/spi_frame_reader_if.sv
// spi_frame_reader_if: request/response signals and SPI pins of one frame reader.
interface spi_frame_reader_if #(
    parameter int NUM_CH  = 1,
    parameter int W       = 16,
    parameter int LO_BITS = 4
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic                 start_transfer;
    logic [CW-1:0]        ch_sel;
    logic [NUM_CH-1:0]    miso;
    logic                 spi_clk;
    logic                 mosi;
    logic [NUM_CH-1:0]    cs_n;
    logic                 busy;
    logic                 data_valid;
    logic [W-1:0]         frame_data;
    logic [W-LO_BITS-1:0] data_hi;
    logic [LO_BITS-1:0]   data_lo;
    logic [CW-1:0]        frame_ch;
    logic                 sel_err;
    // master is the frame reader; slave is the polling controller plus the remote boards
    modport master (
        input  start_transfer, ch_sel, miso,
        output spi_clk, mosi, cs_n, busy, data_valid, frame_data, data_hi, data_lo, frame_ch, sel_err
    );
    modport slave (
        output start_transfer, ch_sel, miso,
        input  spi_clk, mosi, cs_n, busy, data_valid, frame_data, data_hi, data_lo, frame_ch, sel_err
    );
endinterface

// File: rtl/spi_frame_reader.sv
// spi_frame_reader: mode-0 SPI master reading one FRAME_BYTES frame from a selected slave.
module spi_frame_reader #(
    parameter int         CLKS_PER_HALF_BIT = 2,
    parameter int         FRAME_BYTES       = 2,
    parameter int         NUM_CH            = 1,
    parameter int         LO_BITS           = 4,
    parameter logic [7:0] TX_BYTE           = 8'h21,
    parameter int         CS_GAP_CYCLES     = 4
) (
    input logic                clk,
    input logic                reset,
    spi_frame_reader_if.master bus_if
);
    localparam int H    = CLKS_PER_HALF_BIT;
    localparam int W    = 8 * FRAME_BYTES;
    localparam int CW   = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CMAX = 2 * H > CS_GAP_CYCLES ? 2 * H : CS_GAP_CYCLES;
    localparam int NW   = $clog2(CMAX);
    localparam int BW   = $clog2(W);
    localparam logic [NW-1:0] H_END = NW'(H - 1);
    localparam logic [NW-1:0] H_MID = NW'(H);
    localparam logic [NW-1:0] B_END = NW'(2 * H - 1);
    localparam logic [NW-1:0] G_END = NW'(CS_GAP_CYCLES - 1);
    localparam logic [BW-1:0] W_END = BW'(W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     ch_q, ch_d, frame_ch_q;
    logic [NUM_CH-1:0] cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
    logic              valid_q, sel_err_q;
    logic [W-1:0]      sh_q, frame_q;
    logic              accept, ch_ok, rx_bit;

    assign ch_ok  = {1'b0, bus_if.ch_sel} < (CW + 1)'(NUM_CH);
    assign accept = state_q == IDLE && bus_if.start_transfer;
    // only the selected slave's chip select is low, so masking with it picks its MISO
    assign rx_bit = |(bus_if.miso & ~cs_n_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + NW'(1);
        bit_d   = bit_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (accept && ch_ok) begin
                    state_d = SETUP;
                    ch_d    = bus_if.ch_sel;
                end
            end
            SETUP: if (cnt_q == H_END) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: if (cnt_q == B_END) begin
                cnt_d = '0;
                if (bit_q == W_END) state_d = HOLD;
                else bit_d = bit_q + BW'(1);
            end
            HOLD: if (cnt_q == H_END) begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: if (cnt_q == G_END) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pins are registered from the next state so they change cleanly with the FSM
    always_comb begin
        cs_n_d = state_d inside {SETUP, SHIFT, HOLD} ? ~(NUM_CH'(1) << ch_d) : '1;
        sclk_d = state_d == SHIFT && cnt_d >= H_MID;
        mosi_d = state_d inside {SETUP, SHIFT} && TX_BYTE[~bit_d[2:0]];
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_q     <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sel_err_q  <= 1'b0;
            sh_q       <= '0;
            frame_q    <= '0;
            frame_ch_q <= '0;
        end else begin
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            valid_q   <= state_q == DONE;
            sel_err_q <= accept && !ch_ok;
            if (state_q == SHIFT && cnt_q == H_END) sh_q <= {sh_q[W-2:0], rx_bit};
            if (state_q == DONE) begin
                frame_q    <= sh_q;
                frame_ch_q <= ch_q;
            end
        end
    end

    assign bus_if.cs_n       = cs_n_q;
    assign bus_if.spi_clk    = sclk_q;
    assign bus_if.mosi       = mosi_q;
    assign bus_if.busy       = busy_q;
    assign bus_if.data_valid = valid_q;
    assign bus_if.sel_err    = sel_err_q;
    assign bus_if.frame_data = frame_q;
    assign bus_if.data_hi    = frame_q[W-1:LO_BITS];
    assign bus_if.data_lo    = frame_q[LO_BITS-1:0];
    assign bus_if.frame_ch   = frame_ch_q;
endmodule

// File: tb/tb_spi_frame_reader.sv
// tb_spi_frame_reader: directed checks of three reader configurations against hand-computed values.
module tb_spi_frame_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    spi_frame_reader_if #(.NUM_CH(1), .W(16), .LO_BITS(4)) b0 ();
    spi_frame_reader_if #(.NUM_CH(4), .W(16), .LO_BITS(4)) b1 ();
    spi_frame_reader_if #(.NUM_CH(1), .W(24), .LO_BITS(8)) b2 ();

    spi_frame_reader #(.CLKS_PER_HALF_BIT(2), .FRAME_BYTES(2), .NUM_CH(1), .LO_BITS(4))
        u0 (.clk(clk), .reset(reset), .bus_if(b0));
    spi_frame_reader #(.CLKS_PER_HALF_BIT(2), .FRAME_BYTES(2), .NUM_CH(4), .LO_BITS(4))
        u1 (.clk(clk), .reset(reset), .bus_if(b1));
    spi_frame_reader #(.CLKS_PER_HALF_BIT(2), .FRAME_BYTES(3), .NUM_CH(1), .LO_BITS(8))
        u2 (.clk(clk), .reset(reset), .bus_if(b2));

    // mode-0 slaves: MSB presented when CS falls, next bit after each SCLK falling edge
    logic [15:0] feed0 = '0;
    logic [15:0] mo0 = '0;
    int f0 = 0, base0 = 0, r0 = 0;
    always @(negedge b0.cs_n[0]) base0 = f0;
    always @(negedge b0.spi_clk) f0++;
    always @(posedge b0.spi_clk) begin
        r0++;
        mo0 = {mo0[14:0], b0.mosi};
    end
    assign b0.miso = (f0 - base0 < 16) ? feed0[4'(15 - (f0 - base0))] : 1'b0;

    logic [23:0] feed2 = '0;
    logic [23:0] mo2 = '0;
    int f2 = 0, base2 = 0, r2 = 0;
    always @(negedge b2.cs_n[0]) base2 = f2;
    always @(negedge b2.spi_clk) f2++;
    always @(posedge b2.spi_clk) begin
        r2++;
        mo2 = {mo2[22:0], b2.mosi};
    end
    assign b2.miso = (f2 - base2 < 24) ? feed2[5'(23 - (f2 - base2))] : 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go0(input logic [15:0] f, output int cyc, output int low);
        feed0 = f;
        @(negedge clk) b0.start_transfer = 1'b1;
        @(negedge clk) b0.start_transfer = 1'b0;
        cyc = 1;
        low = 0;
        while (!b0.data_valid && cyc < 400) begin
            if (!b0.cs_n[0]) low++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic go1(input logic [1:0] ch, input logic [3:0] m, output int cyc, output logic [3:0] csor);
        b1.ch_sel = ch;
        b1.miso = m;
        @(negedge clk) b1.start_transfer = 1'b1;
        @(negedge clk) b1.start_transfer = 1'b0;
        cyc = 1;
        csor = '0;
        while (!b1.data_valid && cyc < 400) begin
            csor |= ~b1.cs_n;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, low, r, nv, run, gmin, badf;
        logic [3:0] csor;
        b0.start_transfer = 1'b0;
        b0.ch_sel = '0;
        b1.start_transfer = 1'b0;
        b1.ch_sel = '0;
        b1.miso = '0;
        b2.start_transfer = 1'b0;
        b2.ch_sel = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ctl", {b0.cs_n, b0.spi_clk, b0.mosi, b0.busy, b0.data_valid, b0.sel_err}, 6'b100000);
        check("rst_frame", b0.frame_data, 16'h0);
        check("rst_cs_ch4", b1.cs_n, 4'hF);

        r = r0;
        go0(16'hA5C3, cyc, low);
        check("t1_latency", cyc, 70);
        check("t1_frame", b0.frame_data, 16'hA5C3);
        check("t1_hi", b0.data_hi, 12'hA5C);
        check("t1_lo", b0.data_lo, 4'h3);
        check("t1_cs_low_cycles", low, 68);
        check("t1_sclk_rises", r0 - r, 16);
        check("t1_mosi", mo0, 16'h2121);
        check("t1_busy_cs_at_dv", {b0.busy, b0.cs_n}, 2'b11);
        @(negedge clk);
        check("t1_dv_one_cycle", b0.data_valid, 1'b0);
        cyc = 0;
        while (b0.busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t1_gap_len", cyc, 3);

        @(negedge clk) begin
            b0.ch_sel = 1'b1;
            b0.start_transfer = 1'b1;
        end
        @(negedge clk) b0.start_transfer = 1'b0;
        check("sel_err_pulse", {b0.sel_err, b0.busy, b0.cs_n}, 3'b101);
        @(negedge clk);
        check("sel_err_once", {b0.sel_err, b0.busy, b0.frame_data}, {2'b00, 16'hA5C3});
        b0.ch_sel = 1'b0;

        feed0 = 16'h5A3C;
        nv = 0;
        run = 0;
        gmin = 1000;
        badf = 0;
        @(negedge clk) b0.start_transfer = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 200) b0.start_transfer = 1'b0;
            if (b0.data_valid) begin
                nv++;
                if (b0.frame_data !== 16'h5A3C) badf++;
            end
            if (b0.cs_n[0]) run++;
            else begin
                if (run > 0 && nv > 0 && run < gmin) gmin = run;
                run = 0;
            end
        end
        check("b2b_dv_count", nv, 3);
        check("b2b_frames_bad", badf, 0);
        check("b2b_gap_ge_min", gmin >= 4, 1'b1);
        check("b2b_idle_end", b0.busy, 1'b0);

        feed0 = 16'hFFFF;
        r = r0;
        @(negedge clk) b0.start_transfer = 1'b1;
        @(negedge clk) b0.start_transfer = 1'b0;
        cyc = 0;
        while (r0 - r < 9 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_bit9", r0 - r, 9);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("rst_mid_ctl", {b0.cs_n, b0.spi_clk, b0.busy, b0.data_valid}, 4'b1000);
        check("rst_mid_frame", b0.frame_data, 16'h0);
        nv = 0;
        repeat (100) begin
            @(negedge clk);
            if (b0.data_valid) nv++;
        end
        check("rst_mid_no_dv", nv, 0);
        go0(16'h0F0F, cyc, low);
        check("post_rst_latency", cyc, 70);
        check("post_rst_frame", b0.frame_data, 16'h0F0F);

        go1(2'd2, 4'b0100, cyc, csor);
        check("ch2_latency", cyc, 70);
        check("ch2_frame", b1.frame_data, 16'hFFFF);
        check("ch2_frame_ch", b1.frame_ch, 2'd2);
        check("ch2_cs_only", csor, 4'b0100);
        repeat (6) @(negedge clk);
        go1(2'd0, 4'b1110, cyc, csor);
        check("ch0_frame", b1.frame_data, 16'h0000);
        check("ch0_frame_ch", b1.frame_ch, 2'd0);
        check("ch0_cs_only", csor, 4'b0001);
        repeat (6) @(negedge clk);
        go1(2'd3, 4'b1000, cyc, csor);
        check("ch3_frame", {b1.frame_ch, b1.frame_data}, {2'd3, 16'hFFFF});
        check("ch3_cs_only", csor, 4'b1000);

        feed2 = 24'h123456;
        r = r2;
        @(negedge clk) b2.start_transfer = 1'b1;
        @(negedge clk) b2.start_transfer = 1'b0;
        cyc = 1;
        while (!b2.data_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("fb3_latency", cyc, 102);
        check("fb3_frame", b2.frame_data, 24'h123456);
        check("fb3_hi", b2.data_hi, 16'h1234);
        check("fb3_lo", b2.data_lo, 8'h56);
        check("fb3_sclk_rises", r2 - r, 24);
        check("fb3_mosi", mo2, 24'h212121);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
